pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable/flush pair of each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Handles instruction-fetch stalls, data-memory waits, load-use bubbles, branch/jump redirects resolved in MEM, and halt.
- Holds a small state machine (RUN / DWAIT / HALT) plus a data-wait watchdog counter.

Parameters:
DWAIT_MAX, 64, cycles in DWAIT before mem_timeout is set (>=1)
CNT_W, 32, width of performance counters (used only with PIPE_PERF_EN)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous active-high reset
ihit  in  1  instruction memory returned data this cycle
dhit  in  1  data memory completed access this cycle
dmem_req_MEM  in  1  instruction in MEM reads or writes data memory (dREN|dWEN)
halt_MEM  in  1  HALT instruction present in MEM
redirect_MEM  in  1  taken branch or jump resolved in MEM; PC loads target
memtoReg_EX  in  1  instruction in EX is a load
RegWr_EX  in  1  instruction in EX writes a register
rt_EX  in  5  destination register of load in EX
rs_ID  in  5  source register rs of instruction in ID
rt_ID  in  5  source register rt of instruction in ID
pc_en  out  1  PC register update enable
ifid_enable, ifid_flush  out  1 each  IF/ID latch controls
idex_enable, idex_flush  out  1 each  ID/EX latch controls
exmem_enable, exmem_flush  out  1 each  EX/MEM latch controls
memwb_enable, memwb_flush  out  1 each  MEM/WB latch controls
halted  out  1  processor halted (sticky until reset)
mem_timeout  out  1  sticky: a DWAIT exceeded DWAIT_MAX cycles
ctrl_state  out  2  0=RUN, 1=DWAIT, 2=HALT

Behaviour:
- Latch semantics: flush=1 loads a bubble (all-zero) and overrides enable; enable=0 with flush=0 holds the latch.
- Control outputs are combinational from state and inputs (same-cycle). state, wait counter, halted, and mem_timeout are registered.
- RST=1 (sampled at edge):
  - Next state RUN; wait counter 0; halted=0; mem_timeout=0.
  - While RST is high: pc_en=0; all flush=1; all enable=1.
- Conditions, evaluated in priority order:
  1. Memory stall: dmem_req_MEM & ~dhit.
     - pc_en=0; IF/ID, ID/EX, EX/MEM held.
     - memwb_enable=1, memwb_flush=1 (bubble to WB).
     - RUN -> DWAIT.
  2. Halt: halt_MEM.
     - pc_en=0; IF/ID, ID/EX, EX/MEM flushed.
     - MEM/WB enabled so HALT retires.
     - Next state HALT.
  3. Redirect: redirect_MEM.
     - pc_en=1; ifid_flush, idex_flush, exmem_flush=1.
     - memwb_enable=1. ihit is ignored.
  4. Load-use: memtoReg_EX & RegWr_EX & rt_EX!=0 & (rt_EX==rs_ID | rt_EX==rt_ID).
     - pc_en=0; IF/ID held; idex_flush=1.
     - exmem_enable=1, memwb_enable=1.
  5. Fetch stall: ~ihit.
     - pc_en=0; ifid_flush=1.
     - Other latches enabled (older instructions drain).
  6. Otherwise: pc_en=1; all enables=1; no flush.
- DWAIT:
  - Outputs as condition 1 while ~dhit; wait counter increments each cycle, saturating.
  - When the counter reaches DWAIT_MAX, mem_timeout=1 (sticky).
  - On dhit=1: evaluate conditions 2-6 as in RUN (pipeline advances that same cycle); next state RUN; counter cleared.
- HALT:
  - All enables=0, flushes=0, pc_en=0, halted=1.
  - All inputs ignored until RST.
- Simultaneous events:
  - halt_MEM with a memory stall cannot occur in legal code; the memory stall wins.
  - Redirect beats load-use: the ID instruction is squashed anyway.
  - Load-use with ~ihit: load-use outputs apply (IF/ID hold, which also covers the fetch stall).
- rt_EX==0 never triggers load-use.

Optional Feature:
PIPE_PERF_EN
- Defined: adds outputs stall_cnt and flush_cnt (CNT_W each), cleared on RST, frozen in HALT, wrap on overflow.
  - stall_cnt increments every cycle with pc_en=0 in RUN or DWAIT.
  - flush_cnt increments once per redirect cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- RST high 2 cycles, then ihit=1, no hazards -> cycle after reset: pc_en=1, all enables=1, flushes=0, ctrl_state=0.
- dmem_req_MEM=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles pc_en=0, memwb_flush=1, ctrl_state=1; dhit cycle: all enables=1; next ctrl_state=0; mem_timeout=0.
- DWAIT_MAX=4, dhit held 0 for 6 cycles -> mem_timeout=1 after the 4th wait cycle; stays 1 after dhit and until RST.
- Load in EX with rt_EX=5, rs_ID=5 -> one cycle pc_en=0, ifid_enable=0, idex_flush=1; then with rt_EX=0 the next cycle -> normal flow.
- rt_EX=0 with memtoReg_EX=1, rs_ID=0 -> no stall (pc_en=1).
- redirect_MEM=1 with ihit=0 and load-use true -> pc_en=1, ifid/idex/exmem_flush=1.
- halt_MEM=1 -> memwb_enable=1 that cycle; next cycle halted=1, ctrl_state=2, all enables 0 regardless of inputs; RST restores RUN.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch/PC controls exchanged between pipeline_ctrl and the datapath.
// Defining PIPE_PERF_EN adds the stall_cnt/flush_cnt performance counters.
interface pipeline_ctrl_if
`ifdef PIPE_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;

   logic       ihit;
   logic       dhit;
   logic       dmem_req_MEM;
   logic       halt_MEM;
   logic       redirect_MEM;
   logic       memtoReg_EX;
   logic       RegWr_EX;
   logic [4:0] rt_EX;
   logic [4:0] rs_ID;
   logic [4:0] rt_ID;

   logic       pc_en;
   logic       ifid_enable;
   logic       ifid_flush;
   logic       idex_enable;
   logic       idex_flush;
   logic       exmem_enable;
   logic       exmem_flush;
   logic       memwb_enable;
   logic       memwb_flush;
   logic       halted;
   logic       mem_timeout;
   logic [1:0] ctrl_state;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   // Controller side.
   modport master (
      input  ihit, dhit, dmem_req_MEM, halt_MEM, redirect_MEM,
             memtoReg_EX, RegWr_EX, rt_EX, rs_ID, rt_ID,
      output pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
             exmem_enable, exmem_flush, memwb_enable, memwb_flush,
             halted, mem_timeout, ctrl_state
`ifdef PIPE_PERF_EN
      , output stall_cnt, flush_cnt
`endif
   );

   // Datapath side.
   modport slave (
      output ihit, dhit, dmem_req_MEM, halt_MEM, redirect_MEM,
             memtoReg_EX, RegWr_EX, rt_EX, rs_ID, rt_ID,
      input  pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
             exmem_enable, exmem_flush, memwb_enable, memwb_flush,
             halted, mem_timeout, ctrl_state
`ifdef PIPE_PERF_EN
      , input stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline (RUN / DWAIT / HALT).
// Optional PIPE_PERF_EN adds stall and redirect-flush performance counters.
module pipeline_ctrl #(
   parameter int DWAIT_MAX = 64
`ifdef PIPE_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic             CLK,
   input logic             RST,
   pipeline_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } ctrlState_t;

   localparam int                WAIT_W     = $clog2(DWAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DWAIT_MAX);

   ctrlState_t        state;
   ctrlState_t        nextState;
   logic [WAIT_W-1:0] waitCnt;
   logic              haltedQ;
   logic              timeoutQ;

   logic loadUse;
   logic memStall;
   logic takeHalt;
   logic takeRedirect;
   logic takeLoadUse;
   logic takeFetch;

   logic pcEn;
   logic ifidEn;
   logic ifidFl;
   logic idexEn;
   logic idexFl;
   logic exmemEn;
   logic exmemFl;
   logic memwbEn;
   logic memwbFl;

   assign loadUse = bus.memtoReg_EX & bus.RegWr_EX & (bus.rt_EX != 5'd0) &
                    ((bus.rt_EX == bus.rs_ID) | (bus.rt_EX == bus.rt_ID));

   // Once waiting, only dhit releases the stall; dmem_req_MEM is no longer consulted.
   assign memStall = (state == DWAIT) ? ~bus.dhit : (bus.dmem_req_MEM & ~bus.dhit);

   assign takeHalt     = ~memStall & bus.halt_MEM;
   assign takeRedirect = ~memStall & ~bus.halt_MEM & bus.redirect_MEM;
   assign takeLoadUse  = ~memStall & ~bus.halt_MEM & ~bus.redirect_MEM & loadUse;
   assign takeFetch    = ~memStall & ~bus.halt_MEM & ~bus.redirect_MEM & ~loadUse & ~bus.ihit;

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      if (state != HALT) begin
         if (memStall) begin
            nextState = DWAIT;
         end else if (bus.halt_MEM) begin
            nextState = HALT;
         end else begin
            nextState = RUN;
         end
      end
   end

   // A latch being flushed or advancing is enabled; only a held latch drops its enable.
   always_comb begin
      // NOTE: every output gets a default first so no path through the chain infers a latch.
      pcEn    = 1'b0;
      ifidEn  = 1'b1;
      ifidFl  = 1'b0;
      idexEn  = 1'b1;
      idexFl  = 1'b0;
      exmemEn = 1'b1;
      exmemFl = 1'b0;
      memwbEn = 1'b1;
      memwbFl = 1'b0;
      if (RST) begin
         ifidFl  = 1'b1;
         idexFl  = 1'b1;
         exmemFl = 1'b1;
         memwbFl = 1'b1;
      end else if (state == HALT) begin
         ifidEn  = 1'b0;
         idexEn  = 1'b0;
         exmemEn = 1'b0;
         memwbEn = 1'b0;
      end else if (memStall) begin
         ifidEn  = 1'b0;
         idexEn  = 1'b0;
         exmemEn = 1'b0;
         memwbFl = 1'b1;
      end else if (takeHalt) begin
         ifidFl  = 1'b1;
         idexFl  = 1'b1;
         exmemFl = 1'b1;
      end else if (takeRedirect) begin
         pcEn    = 1'b1;
         ifidFl  = 1'b1;
         idexFl  = 1'b1;
         exmemFl = 1'b1;
      end else if (takeLoadUse) begin
         ifidEn  = 1'b0;
         idexFl  = 1'b1;
      end else if (takeFetch) begin
         ifidFl  = 1'b1;
      end else begin
         pcEn    = 1'b1;
      end
   end

   // Watchdog counts DWAIT cycles without dhit; timeout flags as the count reaches DWAIT_MAX.
   always_ff @(posedge CLK) begin
      if (RST) begin
         waitCnt  <= '0;
         haltedQ  <= 1'b0;
         timeoutQ <= 1'b0;
      end else begin
         if (state == DWAIT && !bus.dhit) begin
            if (waitCnt != WAIT_LIMIT) begin
               waitCnt <= waitCnt + 1'b1;
            end
            if (waitCnt >= WAIT_LIMIT - 1'b1) begin
               timeoutQ <= 1'b1;
            end
         end else begin
            waitCnt <= '0;
         end
         if (nextState == HALT) begin
            haltedQ <= 1'b1;
         end
      end
   end

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else if (state != HALT) begin
         if (!pcEn) begin
            stallCnt <= stallCnt + 1'b1;
         end
         if (takeRedirect) begin
            flushCnt <= flushCnt + 1'b1;
         end
      end
   end

   assign bus.stall_cnt = stallCnt;
   assign bus.flush_cnt = flushCnt;
`endif

   assign bus.pc_en        = pcEn;
   assign bus.ifid_enable  = ifidEn;
   assign bus.ifid_flush   = ifidFl;
   assign bus.idex_enable  = idexEn;
   assign bus.idex_flush   = idexFl;
   assign bus.exmem_enable = exmemEn;
   assign bus.exmem_flush  = exmemFl;
   assign bus.memwb_enable = memwbEn;
   assign bus.memwb_flush  = memwbFl;
   assign bus.halted       = haltedQ;
   assign bus.mem_timeout  = timeoutQ;
   assign bus.ctrl_state   = state;

endmodule
